// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between core port C and loader port D.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_c_valid,
    output logic              o_c_ready,
    input  logic              i_c_we,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_c_wdata,
    output logic              o_c_rsp_valid,
    output logic [DATA_W-1:0] o_c_rsp_rdata,
    input  logic              i_d_valid,
    output logic              o_d_ready,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_rsp_valid,
    output logic [DATA_W-1:0] o_d_rsp_rdata,
    input  logic              i_d_lock,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [CNT_W-1:0]  o_perf_c_grants,
    output logic [CNT_W-1:0]  o_perf_d_grants,
    output logic [CNT_W-1:0]  o_perf_c_wait,
`endif
    output logic              o_core_stall
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam logic GrantC = 1'b0;
    localparam logic GrantD = 1'b1;

    typedef enum logic [0:0] {StRr, StLockD} state_e;

    state_e               r_state, w_state_d;
    logic                 r_last_grant, w_last_grant_d;
    logic [BURST_W-1:0]   r_burst_cnt, w_burst_cnt_d;
    logic                 r_c_rsp_valid, r_d_rsp_valid;
    logic [DATA_W-1:0]    r_c_rsp_rdata, r_d_rsp_rdata;
    logic                 w_grant_c, w_grant_d;
    logic                 w_burst_full;

    assign w_burst_full = (r_burst_cnt == BURST_W'(MAX_BURST));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StRr;
            r_last_grant  <= GrantD;
            r_burst_cnt   <= '0;
            r_c_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            r_c_rsp_rdata <= '0;
            r_d_rsp_rdata <= '0;
        end else begin
            r_state       <= w_state_d;
            r_last_grant  <= w_last_grant_d;
            r_burst_cnt   <= w_burst_cnt_d;
            r_c_rsp_valid <= w_grant_c & ~i_c_we;
            r_d_rsp_valid <= w_grant_d & ~i_d_we;
            if (w_grant_c && !i_c_we) r_c_rsp_rdata <= i_mem_rdata;
            if (w_grant_d && !i_d_we) r_d_rsp_rdata <= i_mem_rdata;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_burst_cnt_d  = r_burst_cnt;
        w_last_grant_d = r_last_grant;
        if (w_grant_d)      w_last_grant_d = GrantD;
        else if (w_grant_c) w_last_grant_d = GrantC;
        unique case (r_state)
            StRr: begin
                if (w_grant_d && i_d_lock) begin
                    w_state_d     = StLockD;
                    w_burst_cnt_d = BURST_W'(1);
                end
            end
            StLockD: begin
                if (i_d_valid && i_d_lock) begin
                    if (w_grant_c) begin
                        w_state_d     = StRr;
                        w_burst_cnt_d = '0;
                    end else if (!w_burst_full) begin
                        w_burst_cnt_d = r_burst_cnt + BURST_W'(1);
                    end
                end else begin
                    w_state_d     = StRr;
                    w_burst_cnt_d = '0;
                end
            end
            default: begin
                w_state_d     = StRr;
                w_burst_cnt_d = '0;
            end
        endcase
    end

    // Leaving the lock falls back to plain round-robin in the same cycle.
    always_comb begin
        w_grant_c = 1'b0;
        w_grant_d = 1'b0;
        if (!i_rst) begin
            if (r_state == StLockD && i_d_valid && i_d_lock) begin
                if (w_burst_full && i_c_valid) w_grant_c = 1'b1;
                else                           w_grant_d = 1'b1;
            end else begin
                w_grant_c = i_c_valid & (~i_d_valid | (r_last_grant == GrantD));
                w_grant_d = i_d_valid & (~i_c_valid | (r_last_grant == GrantC));
            end
        end
        o_c_ready     = w_grant_c;
        o_d_ready     = w_grant_d;
        o_mem_addr    = w_grant_d ? i_d_addr  : i_c_addr;
        o_mem_wdata   = w_grant_d ? i_d_wdata : i_c_wdata;
        o_mem_read    = (w_grant_c & ~i_c_we) | (w_grant_d & ~i_d_we);
        o_mem_write   = (w_grant_c & i_c_we) | (w_grant_d & i_d_we);
        o_core_stall  = i_c_valid & ~w_grant_c;
        // A response registered just before reset must not escape during reset.
        o_c_rsp_valid = r_c_rsp_valid & ~i_rst;
        o_d_rsp_valid = r_d_rsp_valid & ~i_rst;
        o_c_rsp_rdata = r_c_rsp_rdata;
        o_d_rsp_rdata = r_d_rsp_rdata;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] r_perf_c_grants, r_perf_d_grants, r_perf_c_wait;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_c_grants <= '0;
            r_perf_d_grants <= '0;
            r_perf_c_wait   <= '0;
        end else begin
            if (w_grant_c && r_perf_c_grants != '1)
                r_perf_c_grants <= r_perf_c_grants + CNT_W'(1);
            if (w_grant_d && r_perf_d_grants != '1)
                r_perf_d_grants <= r_perf_d_grants + CNT_W'(1);
            if (o_core_stall && r_perf_c_wait != '1)
                r_perf_c_wait <= r_perf_c_wait + CNT_W'(1);
        end
    end

    assign o_perf_c_grants = r_perf_c_grants;
    assign o_perf_d_grants = r_perf_d_grants;
    assign o_perf_c_wait   = r_perf_c_wait;
`else
    // Counters absent; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a small behavioural memory behind it.
// Define DMEM_ARB_PERF_EN to also exercise the saturating performance counters.
module tb_dmem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_valid, c_ready, c_we, c_rsp_valid;
    logic [31:0] c_addr, c_wdata, c_rsp_rdata;
    logic        d_valid, d_ready, d_we, d_rsp_valid, d_lock;
    logic [31:0] d_addr, d_wdata, d_rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, core_stall;
`ifdef DMEM_ARB_PERF_EN
    logic [3:0]  perf_c_grants, perf_d_grants, perf_c_wait;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_BURST(4),
        .CNT_W    (4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_c_valid      (c_valid),
        .o_c_ready      (c_ready),
        .i_c_we         (c_we),
        .i_c_addr       (c_addr),
        .i_c_wdata      (c_wdata),
        .o_c_rsp_valid  (c_rsp_valid),
        .o_c_rsp_rdata  (c_rsp_rdata),
        .i_d_valid      (d_valid),
        .o_d_ready      (d_ready),
        .i_d_we         (d_we),
        .i_d_addr       (d_addr),
        .i_d_wdata      (d_wdata),
        .o_d_rsp_valid  (d_rsp_valid),
        .o_d_rsp_rdata  (d_rsp_rdata),
        .i_d_lock       (d_lock),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .i_mem_rdata    (mem_rdata),
`ifdef DMEM_ARB_PERF_EN
        .o_perf_c_grants(perf_c_grants),
        .o_perf_d_grants(perf_d_grants),
        .o_perf_c_wait  (perf_c_wait),
`endif
        .o_core_stall   (core_stall)
    );

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    typedef struct {
        logic        rst;
        logic        cv, cwe;
        logic [31:0] ca, cwd;
        logic        dv, dwe, dl;
        logic [31:0] da, dwd;
        logic        ecr, edr, emr, emw;
        logic [31:0] ema;
        logic        ecrv;
        logic [31:0] ecrd;
        logic        edrv;
        logic [31:0] edrd;
        logic        estall;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        c_valid = v.cv; c_we = v.cwe; c_addr = v.ca; c_wdata = v.cwd;
        d_valid = v.dv; d_we = v.dwe; d_lock = v.dl; d_addr = v.da; d_wdata = v.dwd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;  // 0x10
        mem[5] = 32'h11111111;  // 0x14

        //           rst cv cwe ca        cwd    dv dwe dl da     dwd      cr dr mr mw ma
        //             crv crd            drv drd           stall
        // basic load and response
        tbl.push_back('{L, L,L,32'h0, 32'h0, L,L,L,32'h0, 32'h0,  L,L,L,L,32'h0,  L,32'h0, L,32'h0, L});
        tbl.push_back('{L, H,L,32'h10,32'h0, L,L,L,32'h0, 32'h0,  H,L,H,L,32'h10, L,32'h0, L,32'h0, L});
        tbl.push_back('{L, L,L,32'h0, 32'h0, L,L,L,32'h0, 32'h0,  L,L,L,L,32'h0,  H,32'hDEADBEEF, L,32'h0, L});
        // alternation after reset: C first
        tbl.push_back('{H, L,L,32'h0, 32'h0, L,L,L,32'h0, 32'h0,  L,L,L,L,32'h0,  L,32'h0, L,32'h0, L});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,L,L,32'h14,32'h0,  H,L,H,L,32'h10, L,32'h0, L,32'h0, L});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,L,L,32'h14,32'h0,  L,H,H,L,32'h14, H,32'hDEADBEEF, L,32'h0, H});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,L,L,32'h14,32'h0,  H,L,H,L,32'h10, L,32'h0, H,32'h11111111, L});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,L,L,32'h14,32'h0,  L,H,H,L,32'h14, H,32'hDEADBEEF, L,32'h0, H});
        // locked D burst: 4 D grants, one C grant, D resumes, then unlock lets C in
        tbl.push_back('{H, L,L,32'h0, 32'h0, L,L,L,32'h0, 32'h0,  L,L,L,L,32'h0,  L,32'h0, L,32'h0, L});
        tbl.push_back('{L, L,L,32'h0, 32'h0, H,H,H,32'h30,32'h1,  L,H,L,H,32'h30, L,32'h0, L,32'h0, L});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,H,H,32'h34,32'h2,  L,H,L,H,32'h34, L,32'h0, L,32'h0, H});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,H,H,32'h38,32'h3,  L,H,L,H,32'h38, L,32'h0, L,32'h0, H});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,H,H,32'h3C,32'h4,  L,H,L,H,32'h3C, L,32'h0, L,32'h0, H});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,H,H,32'h40,32'h5,  H,L,H,L,32'h10, L,32'h0, L,32'h0, L});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,H,H,32'h40,32'h5,  L,H,L,H,32'h40, H,32'hDEADBEEF, L,32'h0, H});
        tbl.push_back('{L, H,L,32'h10,32'h0, H,H,L,32'h44,32'h6,  H,L,H,L,32'h10, L,32'h0, L,32'h0, L});
        // same-address contention with last_grant=C
        tbl.push_back('{H, L,L,32'h0, 32'h0, L,L,L,32'h0, 32'h0,  L,L,L,L,32'h0,  L,32'h0, L,32'h0, L});
        tbl.push_back('{L, H,L,32'h10,32'h0, L,L,L,32'h0, 32'h0,  H,L,H,L,32'h10, L,32'h0, L,32'h0, L});
        tbl.push_back('{L, H,L,32'h20,32'h0, H,H,L,32'h20,32'h55, L,H,L,H,32'h20, H,32'hDEADBEEF, L,32'h0, H});
        tbl.push_back('{L, H,L,32'h20,32'h0, L,L,L,32'h0, 32'h0,  H,L,H,L,32'h20, L,32'h0, L,32'h0, L});
        tbl.push_back('{L, L,L,32'h0, 32'h0, L,L,L,32'h0, 32'h0,  L,L,L,L,32'h0,  H,32'h55, L,32'h0, L});
        // reset right after a load accept
        tbl.push_back('{L, H,L,32'h10,32'h0, L,L,L,32'h0, 32'h0,  H,L,H,L,32'h10, L,32'h0, L,32'h0, L});
        tbl.push_back('{H, H,L,32'h14,32'h0, H,L,L,32'h10,32'h0,  L,L,L,L,32'h14, L,32'h0, L,32'h0, H});
        tbl.push_back('{H, H,L,32'h14,32'h0, H,L,L,32'h10,32'h0,  L,L,L,L,32'h14, L,32'h0, L,32'h0, H});
        tbl.push_back('{L, H,L,32'h14,32'h0, H,L,L,32'h10,32'h0,  H,L,H,L,32'h14, L,32'h0, L,32'h0, L});
        tbl.push_back('{L, L,L,32'h0, 32'h0, L,L,L,32'h0, 32'h0,  L,L,L,L,32'h0,  H,32'h11111111, L,32'h0, L});

        rst = 1'b1;
        c_valid = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_valid = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) next_cycle();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("row%0d c_ready", i), {31'b0, c_ready}, {31'b0, tbl[i].ecr});
            check($sformatf("row%0d d_ready", i), {31'b0, d_ready}, {31'b0, tbl[i].edr});
            check($sformatf("row%0d mem_read", i), {31'b0, mem_read}, {31'b0, tbl[i].emr});
            check($sformatf("row%0d mem_write", i), {31'b0, mem_write}, {31'b0, tbl[i].emw});
            check($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].ema);
            check($sformatf("row%0d c_rsp_valid", i), {31'b0, c_rsp_valid}, {31'b0, tbl[i].ecrv});
            check($sformatf("row%0d d_rsp_valid", i), {31'b0, d_rsp_valid}, {31'b0, tbl[i].edrv});
            check($sformatf("row%0d core_stall", i), {31'b0, core_stall}, {31'b0, tbl[i].estall});
            if (tbl[i].ecrv)
                check($sformatf("row%0d c_rsp_rdata", i), c_rsp_rdata, tbl[i].ecrd);
            if (tbl[i].edrv)
                check($sformatf("row%0d d_rsp_rdata", i), d_rsp_rdata, tbl[i].edrd);
            next_cycle();
        end

        // Burst counter saturates while C is idle; C then wins at once.
        rst = 1'b1; c_valid = 1'b0; d_valid = 1'b0; d_lock = 1'b0;
        next_cycle();
        rst = 1'b0;
        d_valid = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 32'h50; d_wdata = 32'h7;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("sat beat%0d d_ready", k), {31'b0, d_ready}, 32'd1);
            next_cycle();
        end
        c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        @(negedge clk);
        check("sat c_ready", {31'b0, c_ready}, 32'd1);
        check("sat d_ready blocked", {31'b0, d_ready}, 32'd0);
        next_cycle();
        c_valid = 1'b0;
        @(negedge clk);
        check("sat d resumes", {31'b0, d_ready}, 32'd1);
        check("sat c_rsp_rdata", c_rsp_rdata, 32'hDEADBEEF);
        next_cycle();
        d_valid = 1'b0; d_lock = 1'b0;

`ifdef DMEM_ARB_PERF_EN
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        repeat (20) next_cycle();
        c_valid = 1'b0;
        @(negedge clk);
        check("perf_c_grants sat", {28'b0, perf_c_grants}, 32'd15);
        check("perf_d_grants", {28'b0, perf_d_grants}, 32'd0);
        check("perf_c_wait", {28'b0, perf_c_wait}, 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("perf_c_grants clr", {28'b0, perf_c_grants}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
